// File: rtl/capture_sequencer.sv
// Capture-array sequencer: latches a host request, pulses each enabled channel's
// select, waits out the sync/capture window, then streams every captured point.
module capture_sequencer #(
    parameter int NCH        = 8,
    parameter int MAXP       = 960,
    parameter int LEVEL_BASE = 200000000,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [9:0]     cfg_n,
    input  logic [9:0]     cfg_np,
    input  logic [NCH-1:0] cfg_mask,
    output logic [9:0]     n,
    output logic [9:0]     np,
    output logic [NCH-1:0] sel_ch,
    input  logic [NCH-1:0] ch_bit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_data,
    output logic [CHW-1:0] out_ch,
    output logic [9:0]     out_idx,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CFG  = 3'd1,
        WAIT = 3'd2,
        READ = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state_r, state_nx_s;
    logic [9:0]     n_r, n_nx_s;
    logic [9:0]     np_r, np_nx_s;
    logic [NCH-1:0] mask_r, mask_nx_s;
    logic [CHW-1:0] k_r, k_nx_s;
    logic [31:0]    wait_r, wait_nx_s;
    logic [NCH-1:0] sel_r, sel_nx_s;
    logic           valid_r, valid_nx_s;
    logic [CHW-1:0] ch_r, ch_nx_s;
    logic [9:0]     idx_r, idx_nx_s;
    logic           busy_r, busy_nx_s;
    logic           done_r, done_nx_s;
    logic [CHW:0]   first_s;
    logic [CHW:0]   next_s;

    function automatic logic [9:0] clamp_np(input logic [9:0] req);
        logic [9:0] res;
        if (req == 10'd0) begin
            res = 10'd1;
        end else if (req > 10'(MAXP)) begin
            res = 10'(MAXP);
        end else begin
            res = req;
        end
        return res;
    endfunction

    // Worst-case sync-plus-capture window, saturating at the counter width.
    function automatic logic [31:0] window_len(input logic [9:0] shift, input logic [9:0] pts);
        logic [31:0] level;
        logic [32:0] sum;
        logic [31:0] res;
        if (shift >= 10'd32) begin
            level = 32'd0;
        end else begin
            level = 32'(LEVEL_BASE) >> shift[4:0];
        end
        sum = {1'b0, level} + {23'd0, pts} + 33'd2;
        if (sum[32]) begin
            res = 32'hFFFF_FFFF;
        end else begin
            res = sum[31:0];
        end
        return res;
    endfunction

    // Lowest enabled channel at or above lo, as {found, index}.
    function automatic logic [CHW:0] find_from(input logic [NCH-1:0] m, input int lo);
        logic [CHW:0] res;
        res = {(CHW+1){1'b0}};
        for (int j = NCH - 1; j >= 0; j--) begin
            if (m[j] && (j >= lo)) begin
                res = {1'b1, CHW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NCH-1:0] select_for(input logic [NCH-1:0] m, input int k);
        logic [NCH-1:0] res;
        res = {NCH{1'b0}};
        if (m[k]) begin
            res[k] = 1'b1;
        end else begin
            res = res;
        end
        return res;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s = state_r;
        n_nx_s     = n_r;
        np_nx_s    = np_r;
        mask_nx_s  = mask_r;
        k_nx_s     = k_r;
        wait_nx_s  = wait_r;
        sel_nx_s   = {NCH{1'b0}};
        ch_nx_s    = ch_r;
        idx_nx_s   = idx_r;
        first_s    = find_from(mask_r, 0);
        next_s     = find_from(mask_r, int'(ch_r) + 1);

        case (state_r)
            IDLE: begin
                if (start) begin
                    n_nx_s    = cfg_n;
                    np_nx_s   = clamp_np(cfg_np);
                    mask_nx_s = cfg_mask;
                    k_nx_s    = {CHW{1'b0}};
                    if (cfg_mask == {NCH{1'b0}}) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = CFG;
                        sel_nx_s   = select_for(cfg_mask, 0);
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CFG: begin
                if (k_r == CHW'(NCH - 1)) begin
                    k_nx_s     = {CHW{1'b0}};
                    wait_nx_s  = window_len(n_r, np_r);
                    state_nx_s = WAIT;
                end else begin
                    k_nx_s   = k_r + CHW'(1);
                    sel_nx_s = select_for(mask_r, int'(k_r) + 1);
                end
            end
            WAIT: begin
                if (wait_r == 32'd1) begin
                    wait_nx_s  = 32'd0;
                    state_nx_s = READ;
                    ch_nx_s    = first_s[CHW-1:0];
                    idx_nx_s   = 10'd0;
                end else begin
                    wait_nx_s = wait_r - 32'd1;
                end
            end
            READ: begin
                if (out_ready) begin
                    if (idx_r < (np_r - 10'd1)) begin
                        idx_nx_s = idx_r + 10'd1;
                    end else if (next_s[CHW]) begin
                        ch_nx_s  = next_s[CHW-1:0];
                        idx_nx_s = 10'd0;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase

        // Abort overrides every transition but keeps the latched configuration.
        if (abort) begin
            state_nx_s = IDLE;
            n_nx_s     = n_r;
            np_nx_s    = np_r;
            mask_nx_s  = mask_r;
            k_nx_s     = {CHW{1'b0}};
            wait_nx_s  = 32'd0;
            sel_nx_s   = {NCH{1'b0}};
        end else begin
            state_nx_s = state_nx_s;
        end

        valid_nx_s = (state_nx_s == READ);
        busy_nx_s  = (state_nx_s != IDLE);
        done_nx_s  = (state_nx_s == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            n_r     <= 10'd0;
            np_r    <= 10'(MAXP);
            mask_r  <= {NCH{1'b0}};
            k_r     <= {CHW{1'b0}};
            wait_r  <= 32'd0;
            sel_r   <= {NCH{1'b0}};
            valid_r <= 1'b0;
            ch_r    <= {CHW{1'b0}};
            idx_r   <= 10'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            n_r     <= n_nx_s;
            np_r    <= np_nx_s;
            mask_r  <= mask_nx_s;
            k_r     <= k_nx_s;
            wait_r  <= wait_nx_s;
            sel_r   <= sel_nx_s;
            valid_r <= valid_nx_s;
            ch_r    <= ch_nx_s;
            idx_r   <= idx_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    assign n         = n_r;
    assign np        = np_r;
    assign sel_ch    = sel_r;
    assign out_valid = valid_r;
    assign out_ch    = ch_r;
    assign out_idx   = idx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    // ch_bit is already muxed by out_idx outside, so only the channel is selected here.
    assign out_data  = ch_bit[ch_r];

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer against a run-level model of the
// expected readout sequence and cycle timeline.
module tb_capture_sequencer;
    localparam int NCH        = 4;
    localparam int MAXP       = 960;
    localparam int LEVEL_BASE = 16;
    localparam int CHW        = 2;

    logic           clk = 1'b0;
    logic           rst, start, abort, out_ready;
    logic [9:0]     cfg_n, cfg_np;
    logic [NCH-1:0] cfg_mask;
    logic [9:0]     n, np, out_idx;
    logic [NCH-1:0] sel_ch, ch_bit;
    logic           out_valid, out_data, busy, done;
    logic [CHW-1:0] out_ch;

    logic [MAXP-1:0] mem [NCH];
    int checks   = 0;
    int failures = 0;

    int first_valid, done_cycle, done_cnt, busy_cnt, busy_last, valid_cnt;
    int stall_err, np_changes, sel_pulses;
    logic [9:0] n_at1, np_at1;
    logic [NCH-1:0] sel_log [64];
    int   hs_ch[$], hs_idx[$], hs_cyc[$];
    logic hs_data[$];
    int   exp_ch[$], exp_idx[$];

    capture_sequencer #(.NCH(NCH), .MAXP(MAXP), .LEVEL_BASE(LEVEL_BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_n(cfg_n), .cfg_np(cfg_np), .cfg_mask(cfg_mask),
        .n(n), .np(np), .sel_ch(sel_ch), .ch_bit(ch_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Channel bank: each channel's point array indexed by out_idx.
    always_comb begin
        for (int j = 0; j < NCH; j++) ch_bit[j] = mem[j][out_idx];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_np(input int req);
        if (req == 0) return 1;
        if (req > MAXP) return MAXP;
        return req;
    endfunction

    function automatic int model_w(input int sh, input int pts);
        int lvl;
        lvl = (sh >= 32) ? 0 : (LEVEL_BASE >> sh);
        return lvl + pts + 2;
    endfunction

    task automatic build_expected(input logic [NCH-1:0] m, input int pts);
        exp_ch.delete();
        exp_idx.delete();
        for (int c = 0; c < NCH; c++)
            if (m[c])
                for (int i = 0; i < pts; i++) begin
                    exp_ch.push_back(c);
                    exp_idx.push_back(i);
                end
    endtask

    // Index of the first handshake differing from the first len expected points, or -1.
    function automatic int seq_first_bad(input int len);
        int lim;
        lim = (hs_ch.size() < len) ? hs_ch.size() : len;
        for (int i = 0; i < lim; i++)
            if (hs_ch[i] != exp_ch[i] || hs_idx[i] != exp_idx[i] ||
                hs_data[i] !== mem[exp_ch[i]][exp_idx[i]]) return i;
        if (hs_ch.size() != len) return lim;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run from IDLE; mode 0 ready=1, 1 toggling, 2 random.
    task automatic do_run(input logic [9:0] cn, input logic [9:0] cnp, input logic [NCH-1:0] cm,
                          input int mode, input int abort_at, input int rst_at,
                          input int restart_at, input int max_cycles);
        int cycle, vseen, p_ch, p_idx;
        logic stalled, p_data, r;
        for (int j = 0; j < NCH; j++)
            for (int i = 0; i < MAXP; i++) mem[j][i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 64; i++) sel_log[i] = '0;
        first_valid = 0; done_cycle = 0; done_cnt = 0; busy_cnt = 0; busy_last = 0;
        valid_cnt = 0; stall_err = 0; np_changes = 0; sel_pulses = 0;
        hs_ch.delete(); hs_idx.delete(); hs_cyc.delete(); hs_data.delete();
        cfg_n = cn; cfg_np = cnp; cfg_mask = cm; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_n = 10'($urandom); cfg_np = 10'($urandom); cfg_mask = 4'($urandom);
        cycle = 1; vseen = 0; stalled = 1'b0; p_ch = 0; p_idx = 0; p_data = 1'b0;
        while (cycle <= max_cycles) begin
            if (cycle == 1) begin n_at1 = n; np_at1 = np; end
            if (cycle < 64) sel_log[cycle] = sel_ch;
            if (sel_ch != '0) sel_pulses++;
            if (busy) begin
                busy_cnt++; busy_last = cycle;
                if (n !== n_at1 || np !== np_at1) np_changes++;
            end
            if (done) begin done_cnt++; done_cycle = cycle; end
            if (stalled && (out_valid !== 1'b1 || int'(out_ch) != p_ch ||
                            int'(out_idx) != p_idx || out_data !== p_data)) stall_err++;
            abort = (cycle == abort_at);
            rst   = (cycle == rst_at);
            if (cycle == restart_at) begin
                start = 1'b1; cfg_n = 10'd7; cfg_np = 10'd3; cfg_mask = 4'b1111;
            end
            case (mode)
                0: r = 1'b1;
                1: r = (vseen % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (out_valid) begin
                if (first_valid == 0) first_valid = cycle;
                valid_cnt++; vseen++;
                if (r) begin
                    hs_ch.push_back(int'(out_ch)); hs_idx.push_back(int'(out_idx));
                    hs_data.push_back(out_data); hs_cyc.push_back(cycle);
                end
            end
            stalled = out_valid && !r;
            p_ch = int'(out_ch); p_idx = int'(out_idx); p_data = out_data;
            if (!busy) break;
            tick();
            abort = 1'b0; rst = 1'b0; start = 1'b0;
            cycle++;
        end
        if (cycle > max_cycles) begin
            checks++; failures++;
            $display("FAIL run_timeout: busy still %0b after %0d cycles, required idle", busy, max_cycles);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cfg_n = 10'd5; cfg_np = 10'd5; cfg_mask = 4'b1111;
        tick(); tick();
        rst = 1'b0;
        if (n !== 10'd0) begin failures++; $display("FAIL reset_n: got %0d want 0", n); end
        checks++;
        if (np !== 10'd960) begin failures++; $display("FAIL reset_np: got %0d want 960", np); end
        checks++;
        if (sel_ch !== 4'b0000) begin failures++; $display("FAIL reset_sel: got %b want 0000", sel_ch); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_ch !== 2'd0 || out_idx !== 10'd0) begin
            failures++; $display("FAIL reset_ptr: got ch %0d idx %0d want 0 0", out_ch, out_idx);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got busy %b done %b want 0 0", busy, done);
        end
        checks++;
    endtask

    task automatic test_basic();
        int w, bad;
        w = model_w(2, 8);
        build_expected(4'b0101, 8);
        do_run(10'd2, 10'd8, 4'b0101, 0, 0, 0, 0, 2000);
        if (sel_log[1] !== 4'b0001 || sel_log[2] !== 4'b0000 || sel_log[3] !== 4'b0100 || sel_log[4] !== 4'b0000) begin
            failures++;
            $display("FAIL basic_sel: got %b %b %b %b want 0001 0000 0100 0000", sel_log[1], sel_log[2], sel_log[3], sel_log[4]);
        end
        checks++;
        if (first_valid != NCH + w + 1) begin failures++; $display("FAIL basic_first_valid: got %0d want %0d", first_valid, NCH + w + 1); end
        checks++;
        if (valid_cnt != 16) begin failures++; $display("FAIL basic_valid_cnt: got %0d want 16", valid_cnt); end
        checks++;
        bad = seq_first_bad(exp_ch.size());
        if (bad != -1) begin failures++; $display("FAIL basic_seq: first bad point %0d, got %0d points want %0d", bad, hs_ch.size(), exp_ch.size()); end
        checks++;
        if (done_cycle != NCH + w + 16 + 1 || done_cnt != 1) begin
            failures++; $display("FAIL basic_done: got cycle %0d count %0d want %0d 1", done_cycle, done_cnt, NCH + w + 17);
        end
        checks++;
        if (busy_cnt != NCH + w + 17 || busy_last != NCH + w + 17) begin
            failures++; $display("FAIL basic_busy: got %0d cycles last %0d want %0d", busy_cnt, busy_last, NCH + w + 17);
        end
        checks++;
        if (n_at1 !== 10'd2 || np_at1 !== 10'd8 || np_changes != 0) begin
            failures++; $display("FAIL basic_cfg: got n %0d np %0d changes %0d want 2 8 0", n_at1, np_at1, np_changes);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        int bad;
        build_expected(4'b0101, 8);
        do_run(10'd2, 10'd8, 4'b0101, 1, 0, 0, 0, 2000);
        if (stall_err != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        checks++;
        bad = seq_first_bad(16);
        if (bad != -1) begin failures++; $display("FAIL bp_seq: first bad point %0d, got %0d handshakes want 16", bad, hs_ch.size()); end
        checks++;
        if (hs_cyc.size() == 0 || done_cycle != hs_cyc[hs_cyc.size()-1] + 1 || done_cnt != 1) begin
            failures++; $display("FAIL bp_done: got done cycle %0d count %0d, last handshake entry count %0d", done_cycle, done_cnt, hs_cyc.size());
        end
        checks++;
    endtask

    task automatic test_clamp_zero_mask();
        int bad;
        build_expected(4'b0001, model_np(0));
        do_run(10'd0, 10'd0, 4'b0001, 0, 0, 0, 0, 2000);
        if (np_at1 !== 10'(model_np(0))) begin failures++; $display("FAIL clamp_low: got np %0d want %0d", np_at1, model_np(0)); end
        checks++;
        bad = seq_first_bad(exp_ch.size());
        if (bad != -1) begin failures++; $display("FAIL clamp_low_seq: got %0d points want %0d", hs_ch.size(), exp_ch.size()); end
        checks++;
        build_expected(4'b1000, model_np(1000));
        do_run(10'd1, 10'd1000, 4'b1000, 0, 0, 0, 0, 5000);
        if (np_at1 !== 10'(model_np(1000))) begin failures++; $display("FAIL clamp_high: got np %0d want %0d", np_at1, model_np(1000)); end
        checks++;
        bad = seq_first_bad(exp_ch.size());
        if (bad != -1) begin failures++; $display("FAIL clamp_high_seq: first bad %0d got %0d points want %0d", bad, hs_ch.size(), exp_ch.size()); end
        checks++;
        if (done_cycle != NCH + model_w(1, 960) + 960 + 1) begin
            failures++; $display("FAIL clamp_high_done: got %0d want %0d", done_cycle, NCH + model_w(1, 960) + 961);
        end
        checks++;
        do_run(10'd3, 10'd5, 4'b0000, 0, 0, 0, 0, 100);
        if (done_cycle != 1 || done_cnt != 1 || busy_cnt != 1) begin
            failures++; $display("FAIL zero_mask_done: got done cycle %0d count %0d busy %0d want 1 1 1", done_cycle, done_cnt, busy_cnt);
        end
        checks++;
        if (sel_pulses != 0 || valid_cnt != 0) begin
            failures++; $display("FAIL zero_mask_quiet: got sel %0d valid %0d want 0 0", sel_pulses, valid_cnt);
        end
        checks++;
    endtask

    task automatic test_abort();
        int bad;
        do_run(10'd2, 10'd8, 4'b0101, 0, 9, 0, 0, 2000);
        if (busy_last != 9 || done_cnt != 0 || valid_cnt != 0) begin
            failures++; $display("FAIL abort_wait: got last busy %0d done %0d valid %0d want 9 0 0", busy_last, done_cnt, valid_cnt);
        end
        checks++;
        if (n !== 10'd2 || np !== 10'd8 || sel_ch !== 4'b0000 || done !== 1'b0) begin
            failures++; $display("FAIL abort_wait_state: got n %0d np %0d sel %b done %b want 2 8 0000 0", n, np, sel_ch, done);
        end
        checks++;
        build_expected(4'b0101, 8);
        do_run(10'd2, 10'd8, 4'b0101, 0, 22, 0, 0, 2000);
        bad = seq_first_bad(4);
        if (bad != -1 || valid_cnt != 4) begin
            failures++; $display("FAIL abort_read_seq: got %0d handshakes %0d valid want 4 4", hs_ch.size(), valid_cnt);
        end
        checks++;
        if (busy_last != 22 || done_cnt != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL abort_read: got last busy %0d done %0d valid %b want 22 0 0", busy_last, done_cnt, out_valid);
        end
        checks++;
        do_run(10'd2, 10'd8, 4'b0101, 0, 0, 0, 0, 2000);
        bad = seq_first_bad(16);
        if (bad != -1 || done_cycle != 35 || done_cnt != 1) begin
            failures++; $display("FAIL abort_restart: got done cycle %0d count %0d bad %0d want 35 1 -1", done_cycle, done_cnt, bad);
        end
        checks++;
    endtask

    task automatic test_control();
        int bad;
        build_expected(4'b0101, 8);
        do_run(10'd2, 10'd8, 4'b0101, 0, 0, 0, 20, 2000);
        bad = seq_first_bad(16);
        if (bad != -1 || np_changes != 0 || done_cycle != 35) begin
            failures++; $display("FAIL start_busy: got bad %0d changes %0d done %0d want -1 0 35", bad, np_changes, done_cycle);
        end
        checks++;
        if (n !== 10'd2 || np !== 10'd8) begin failures++; $display("FAIL start_busy_cfg: got n %0d np %0d want 2 8", n, np); end
        checks++;
        do_run(10'd2, 10'd8, 4'b0101, 0, 0, 29, 0, 2000);
        if (busy_last != 29 || done_cnt != 0) begin
            failures++; $display("FAIL rst_read: got last busy %0d done %0d want 29 0", busy_last, done_cnt);
        end
        checks++;
        if (n !== 10'd0 || np !== 10'd960 || out_valid !== 1'b0 || out_ch !== 2'd0 ||
            out_idx !== 10'd0 || sel_ch !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_read_state: got n %0d np %0d valid %b ch %0d idx %0d sel %b done %b want 0 960 0 0 0 0000 0",
                     n, np, out_valid, out_ch, out_idx, sel_ch, done);
        end
        checks++;
        do_run(10'd40, 10'd8, 4'b0101, 0, 0, 0, 0, 2000);
        if (first_valid != NCH + model_w(40, 8) + 1 || n_at1 !== 10'd40) begin
            failures++; $display("FAIL big_shift: got first valid %0d n %0d want %0d 40", first_valid, n_at1, NCH + model_w(40, 8) + 1);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [9:0] cn, cnp;
        logic [NCH-1:0] cm;
        logic [NCH-1:0] want_sel;
        int pts, w, cnt, bad;
        for (int it = 0; it < 5; it++) begin
            cn  = ($urandom_range(0, 3) == 0) ? 10'd33 : 10'($urandom_range(0, 5));
            cnp = 10'($urandom_range(0, 12));
            cm  = 4'($urandom_range(0, 15));
            pts = model_np(int'(cnp));
            w   = model_w(int'(cn), pts);
            build_expected(cm, pts);
            cnt = exp_ch.size();
            do_run(cn, cnp, cm, 2, 0, 0, 0, 3000);
            bad = seq_first_bad(cnt);
            if (bad != -1) begin failures++; $display("FAIL rand_seq[%0d]: first bad %0d got %0d points want %0d", it, bad, hs_ch.size(), cnt); end
            checks++;
            if (done_cnt != 1 || busy_last != done_cycle || stall_err != 0) begin
                failures++; $display("FAIL rand_end[%0d]: got done %0d last busy %0d done cycle %0d stalls %0d", it, done_cnt, busy_last, done_cycle, stall_err);
            end
            checks++;
            for (int k = 0; k < NCH; k++) begin
                want_sel = cm[k] ? 4'(1 << k) : 4'b0000;
                if (cm != 4'b0000 && sel_log[k+1] !== want_sel) begin
                    failures++; $display("FAIL rand_sel[%0d] k%0d: got %b want %b", it, k, sel_log[k+1], want_sel);
                end
                checks++;
            end
            if (cm != 4'b0000 && first_valid != NCH + w + 1) begin
                failures++; $display("FAIL rand_first_valid[%0d]: got %0d want %0d", it, first_valid, NCH + w + 1);
            end else if (cm == 4'b0000 && done_cycle != 1) begin
                failures++; $display("FAIL rand_zero_done[%0d]: got %0d want 1", it, done_cycle);
            end
            checks++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cfg_n = 10'd0; cfg_np = 10'd0; cfg_mask = 4'b0000;
        for (int j = 0; j < NCH; j++) mem[j] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_clamp_zero_mask();
        test_abort();
        test_control();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
